// File: rtl/kband_mem_pkg.sv
// Shared constants and types for the KBand on-chip RAM arbiter.
package kband_mem_pkg;

   localparam int unsigned ADDR_W     = 13;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned BE_W       = DATA_W / 8;
   localparam int unsigned MEM_DEPTH  = 1 << ADDR_W;
   localparam int unsigned RD_LATENCY = 3;
   localparam int unsigned LOCK_MAX   = 64;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_id_t;

   // Travels alongside a read so its data can be routed back to the issuer.
   typedef struct packed {
      logic     valid;
      port_id_t port;
   } owner_tag_t;

endpackage

// File: rtl/kband_mem_arbiter_if.sv
// Host-side bus bundle for both requesters of the RAM arbiter.
interface kband_mem_arbiter_if #(
   parameter int unsigned ADDR_W = kband_mem_pkg::ADDR_W,
   parameter int unsigned DATA_W = kband_mem_pkg::DATA_W,
   parameter int unsigned BE_W   = kband_mem_pkg::BE_W
) ();

   logic [ADDR_W-1:0] m0_address;
   logic [BE_W-1:0]   m0_byteenable;
   logic              m0_read;
   logic              m0_write;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;

   logic [ADDR_W-1:0] m1_address;
   logic [BE_W-1:0]   m1_byteenable;
   logic              m1_read;
   logic              m1_write;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;
   logic              m1_lock;

   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid
   );

   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
      output m1_waitrequest, m1_readdata, m1_readdatavalid
   );

endinterface

// File: rtl/kband_mem_rd_return.sv
// Read return path: owner-tag pipe, readdata capture and per-port valid demux.
module kband_mem_rd_return #(
   parameter int unsigned DATA_W = kband_mem_pkg::DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  kband_mem_pkg::owner_tag_t  issue_tag,
   input  logic [DATA_W-1:0]          mem_readdata,
   output logic [DATA_W-1:0]          m0_readdata,
   output logic                       m0_readdatavalid,
   output logic [DATA_W-1:0]          m1_readdata,
   output logic                       m1_readdatavalid
);

   import kband_mem_pkg::*;

   owner_tag_t tag_s1;
   owner_tag_t tag_s2;
   logic       ret0;
   logic       ret1;

   // Tag stage 1 lines up with the RAM command, stage 2 with RAM q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_s1 <= '{valid: 1'b0, port: PORT0};
         tag_s2 <= '{valid: 1'b0, port: PORT0};
      end else begin
         tag_s1 <= issue_tag;
         tag_s2 <= tag_s1;
      end
   end

   // Decode which port owns the data currently on RAM q.
   always_comb begin
      ret0 = tag_s2.valid && (tag_s2.port == PORT0);
      ret1 = tag_s2.valid && (tag_s2.port == PORT1);
   end

   // Capture RAM q for the owning port only; the other port holds its data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m0_readdata      <= '0;
         m0_readdatavalid <= 1'b0;
         m1_readdata      <= '0;
         m1_readdatavalid <= 1'b0;
      end else begin
         m0_readdatavalid <= ret0;
         m1_readdatavalid <= ret1;
         if (ret0) m0_readdata <= mem_readdata;
         if (ret1) m1_readdata <= mem_readdata;
      end
   end

endmodule

// File: rtl/kband_mem_arbiter.sv
// Two-port round-robin arbiter with port-1 burst lock for one single-port RAM.
module kband_mem_arbiter #(
   parameter int unsigned ADDR_W   = kband_mem_pkg::ADDR_W,
   parameter int unsigned DATA_W   = kband_mem_pkg::DATA_W,
   parameter int unsigned BE_W     = kband_mem_pkg::BE_W,
   parameter int unsigned LOCK_MAX = kband_mem_pkg::LOCK_MAX
) (
   input  logic                clk,
   input  logic                reset,
   kband_mem_arbiter_if.slave  host,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [BE_W-1:0]     mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   import kband_mem_pkg::*;

   localparam int unsigned       CNT_W      = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0]  LOCK_MAX_C = CNT_W'(LOCK_MAX);

   logic             req0;
   logic             req1;
   logic             grant0;
   logic             grant1;
   logic             lock_sat;
   port_id_t         rr_ptr;
   port_id_t         rr_ptr_nxt;
   logic [CNT_W-1:0] lock_cnt;
   logic [CNT_W-1:0] lock_cnt_nxt;
   owner_tag_t       issue_tag;

   assign req0     = host.m0_read | host.m0_write;
   assign req1     = host.m1_read | host.m1_write;
   assign lock_sat = (lock_cnt == LOCK_MAX_C);

   assign host.m0_waitrequest = ~grant0;
   assign host.m1_waitrequest = ~grant1;

   // Combinational grant: lock override first, then round-robin, then sole requester.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset) begin
         if (host.m1_lock && req1) begin
            if (lock_sat && req0) grant0 = 1'b1;
            else                  grant1 = 1'b1;
         end else if (req0 && req1) begin
            if (rr_ptr == PORT0) grant0 = 1'b1;
            else                 grant1 = 1'b1;
         end else begin
            grant0 = req0;
            grant1 = req1;
         end
      end
   end

   // Next priority holder and lock window count.
   always_comb begin
      rr_ptr_nxt   = rr_ptr;
      lock_cnt_nxt = lock_cnt;
      if (grant0)      rr_ptr_nxt = PORT1;
      else if (grant1) rr_ptr_nxt = PORT0;
      if (!host.m1_lock || grant0)
         lock_cnt_nxt = '0;
      else if (grant1 && req0 && !lock_sat)
         lock_cnt_nxt = lock_cnt + 1'b1;
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr   <= PORT0;
         lock_cnt <= '0;
      end else begin
         rr_ptr   <= rr_ptr_nxt;
         lock_cnt <= lock_cnt_nxt;
      end
   end

   // Read+write together is handled as a write, so only pure reads get a tag.
   always_comb begin
      issue_tag.valid = (grant0 && host.m0_read && !host.m0_write) ||
                        (grant1 && host.m1_read && !host.m1_write);
      issue_tag.port  = grant1 ? PORT1 : PORT0;
   end

   // Register the accepted command toward the RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_address    <= '0;
         mem_byteenable <= '0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         mem_clken      <= 1'b0;
      end else begin
         mem_clken      <= 1'b1;
         mem_chipselect <= grant0 | grant1;
         mem_write      <= (grant0 & host.m0_write) | (grant1 & host.m1_write);
         if (grant1) begin
            mem_address    <= host.m1_address;
            mem_byteenable <= host.m1_byteenable;
            mem_writedata  <= host.m1_writedata;
         end else if (grant0) begin
            mem_address    <= host.m0_address;
            mem_byteenable <= host.m0_byteenable;
            mem_writedata  <= host.m0_writedata;
         end
      end
   end

   kband_mem_rd_return #(
      .DATA_W (DATA_W)
   ) u_rd_return (
      .clk              (clk),
      .reset            (reset),
      .issue_tag        (issue_tag),
      .mem_readdata     (mem_readdata),
      .m0_readdata      (host.m0_readdata),
      .m0_readdatavalid (host.m0_readdatavalid),
      .m1_readdata      (host.m1_readdata),
      .m1_readdatavalid (host.m1_readdatavalid)
   );

   a_m0_rd_wr_excl: assert property (@(posedge clk) disable iff (reset)
                                     !(host.m0_read && host.m0_write));
   a_m1_rd_wr_excl: assert property (@(posedge clk) disable iff (reset)
                                     !(host.m1_read && host.m1_write));

endmodule

// File: doc/kband_mem_arbiter.md
Name: kband_mem_arbiter

Overview:
- Shares one single-port 8192x32 on-chip RAM (byte-enabled, 1-cycle synchronous read, unregistered q) between two Avalon-MM style requesters.
- Port 0 is the HPS lightweight-bridge host; port 1 is the KBand alignment engine.
- Round-robin grant per cycle; port 1 may lock the RAM for bounded bursts.
- Commands are registered toward the RAM, and read data is routed back to the issuing port with fixed latency.

Parameters:
- ADDR_W, 13, word address width (8192 words).
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- LOCK_MAX, 64, maximum consecutive port-1 grants under lock while port 0 is requesting.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  port 0 word address
- m0_byteenable  in  BE_W  port 0 byte lanes
- m0_read  in  1  port 0 read request
- m0_write  in  1  port 0 write request
- m0_writedata  in  DATA_W  port 0 write data
- m0_waitrequest  out  1  port 0 command not accepted this cycle
- m0_readdata  out  DATA_W  port 0 read data
- m0_readdatavalid  out  1  port 0 read data valid
- m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_waitrequest, m1_readdata, m1_readdatavalid  (same as port 0, for port 1)
- m1_lock  in  1  port 1 requests exclusive consecutive grants
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  BE_W  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable; constant 1 after reset
- mem_readdata  in  DATA_W  RAM q (valid the cycle after the RAM samples the address)

Behaviour:
- Reset values: all waitrequest outputs 1; readdatavalid 0; readdata 0; mem_chipselect 0; mem_write 0; mem_address, mem_byteenable and mem_writedata 0; mem_clken 0. The round-robin pointer points to port 0 and the lock counter is 0.
- A port requests when read|write is high. read&write together on one port is illegal and is treated as write; an assertion flags it.
- Grant decision is combinational each cycle. waitrequest_n = ~grant_n. At most one grant per cycle.
- Arbitration:
  - Sole requester wins.
  - When both request, the port other than the last-granted one wins (round-robin).
  - Lock override: while m1_lock=1 and port 1 requests, port 1 wins, unless lock_cnt==LOCK_MAX and port 0 requests. In that case port 0 gets exactly one grant and lock_cnt clears.
  - lock_cnt increments on each port-1 grant while m0 is requesting and m1_lock=1. It clears when m1_lock=0 or on any port-0 grant. It saturates at LOCK_MAX.
- Command stage: an accepted command in cycle N is registered and drives mem_* in cycle N+1 with mem_chipselect=1 and mem_write set for writes. With no accept, mem_chipselect=0 and mem_write=0 in N+1.
- Read return:
  - The RAM samples at the end of N+1; mem_readdata is valid in N+2.
  - The arbiter registers it, so mx_readdata and mx_readdatavalid are asserted in cycle N+3 for the issuing port only.
  - Read latency is exactly 3 cycles from accept. Back-to-back reads return one per cycle in order.
  - An owner tag (port id + valid) is pipelined 2 stages alongside.
- Writes produce no response. A write accepted at N is visible to a read accepted at N+1 or later; the RAM is single-port and sequential by construction.
- The non-granted port's readdata holds its last value; its readdatavalid=0.
- Throughput: one command per cycle total. No bubbles on grant switch.
- Reset mid-operation clears in-flight tags; no readdatavalid is emitted for reads accepted before reset.

Decomposition:
- Package kband_mem_pkg: ADDR_W=13, DATA_W=32, BE_W=4, MEM_DEPTH=8192, RD_LATENCY=3, and the owner-tag typedef (port id bit + valid).
- One sub-module, kband_mem_rd_return: the 2-stage tag pipe, readdata register and per-port valid demux.

Test Plan:
- Single port 0: write 0x1234ABCD to 0x0010 with BE=4'hF, then read 0x0010 → m0_readdatavalid exactly 3 cycles after accept, data 0x1234ABCD; m1_readdatavalid stays 0.
- Byte enables: write 0xFFFFFFFF to 0x1FFF, then 0x00000000 with BE=4'b0101, then read → 0xFF00FF00; last address confirms no wrap errors.
- Contention without lock: both ports issue continuous reads → grants alternate 0,1,0,1; each port gets every other accept and its own data only.
- Lock starvation bound: m1_lock=1 with continuous port-1 reads and port 0 requesting → 64 port-1 grants, then 1 port-0 grant, repeating; m0_waitrequest is never low for more than 1 cycle per window.
- Reset mid-burst: 3 reads in flight on port 1, assert reset for 1 cycle → no readdatavalid afterward, all outputs at reset values, first post-reset read returns correct data at latency 3.
- Write-then-read on alternate ports: port 1 writes 0xDEADBEEF to 0x0100 at cycle N, port 0 reads 0x0100 at N+1 → port 0 gets 0xDEADBEEF at N+4.
